// File: rtl/uart_transmitter_pkg.sv
// Shared constants for the UART transmitter: FSM state encodings and default line timing.
package uart_transmitter_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] TX_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] TX_START  = 3'd1;
    localparam logic [STATE_W-1:0] TX_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] TX_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] TX_STOP   = 3'd4;

    localparam int unsigned DEFAULT_CLK_FREQ = 50000000;
    localparam int unsigned DEFAULT_BAUD     = 115200;

endpackage

// File: rtl/uart_transmitter_baud_tick_gen.sv
// Bit-period counter (0..CLKS_PER_BIT-1) with synchronous clear; flags the last clock of each bit.
module uart_transmitter_baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_end_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so every frame starts with a full-length first bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_c = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter, 8N1 by default. Define UART_TX_PARITY_EN to insert a parity bit
// (sense chosen by PARITY_ODD) between the data bits and the stop bit.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 txEnable,
    input  logic [DATA_BITS-1:0] txData,
    output logic                 tx,
    output logic                 busyTx,
    output logic                 txDone
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BIT_W        = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_transmitter: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_transmitter: DATA_BITS must be 5..9");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_transmitter: PARITY_ODD must be 0 or 1");
    end

    logic [STATE_W-1:0]   state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept_c;
    logic                 bit_end_c;

    assign accept_c = (state_q == TX_IDLE) && txEnable;

    uart_transmitter_baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (accept_c),
        .en_i     (busy_q),
        .bit_end_c(bit_end_c)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;

    // Parity is taken from the word at accept, before the shift register consumes it.
    assign par_d = accept_c ? ((^txData) ^ 1'(PARITY_ODD)) : par_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // Next-state and registered-output logic; tx_d is the line value for the coming bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            TX_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (txEnable) begin
                    shift_d = txData;
                    state_d = TX_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end_c) begin
                    state_d   = TX_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end_c) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = par_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end_c) begin
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (bit_end_c) begin
                    state_d = TX_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx     = tx_q;
    assign busyTx = busy_q;
    assign txDone = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected frames, a negedge monitor
// reconstructs each frame from tx/busyTx/txDone and compares it cycle by cycle.
module tb_uart_transmitter;

    localparam int unsigned CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PBIT = 1;
`else
    localparam int unsigned PBIT = 0;
`endif
    localparam int unsigned PODD      = 0;
    localparam int          FRAME_LEN = (10 + PBIT) * CPB;
    localparam int          ABORT_LEN = 35;

    typedef struct {
        logic [7:0] data;
        int         len;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       txEnable;
    logic [7:0] txData;
    logic       tx;
    logic       busyTx;
    logic       txDone;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   in_frame = 1'b0;
    int   len = 0;
    int   bad = 0;

    uart_transmitter #(
        .CLK_FREQ  (1000000),
        .BAUD      (100000),
        .DATA_BITS (8),
        .PARITY_ODD(PODD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .txEnable(txEnable),
        .txData  (txData),
        .tx      (tx),
        .busyTx  (busyTx),
        .txDone  (txDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected line level at frame cycle i for word d.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int idx;
        idx = i / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PBIT == 1 && idx == 9) return (^d) ^ 1'(PODD);
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (busyTx === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    len = 0;
                    bad = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                        cur.data = 8'h00;
                        cur.len  = FRAME_LEN;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (tx !== exp_bit(cur.data, len)) bad++;
                if (txDone !== 1'b0) bad++;
                len++;
            end else if (in_frame) begin
                in_frame = 1'b0;
                check($sformatf("frame_%02h_len", cur.data), len, cur.len);
                check($sformatf("frame_%02h_wave", cur.data), bad, 0);
                check($sformatf("frame_%02h_done", cur.data), {31'd0, txDone}, (cur.len == FRAME_LEN) ? 1 : 0);
                check($sformatf("frame_%02h_end_tx", cur.data), {31'd0, tx}, 1);
            end else begin
                check("idle_line", {30'd0, tx, txDone}, 32'd2);
            end
        end
    end

    task automatic wait_not_busy(input int budget);
        int n = 0;
        while (busyTx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busyTx !== 1'b0) check("busy_timeout", {31'd0, busyTx}, 0);
    endtask

    task automatic send(input logic [7:0] d, input int exp_len);
        exp_t e;
        wait_not_busy(300);
        e.data = d;
        e.len  = exp_len;
        exp_q.push_back(e);
        txData   = d;
        txEnable = 1'b1;
        @(negedge clk);
        txEnable = 1'b0;
    endtask

    initial begin
        exp_t e;
        int n;
        reset    = 1'b1;
        txEnable = 1'b0;
        txData   = 8'h00;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        // Basic frame
        send(8'h55, FRAME_LEN);
        wait_not_busy(300);
        repeat (3) @(negedge clk);

        // Requests and data changes while busy must not disturb the frame or queue another
        send(8'h3C, FRAME_LEN);
        repeat (20) @(negedge clk);
        txEnable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            txData = 8'hA3 + 8'(i);
            @(negedge clk);
        end
        txEnable = 1'b0;
        wait_not_busy(300);
        repeat (3) @(negedge clk);

        // Enable held high: second frame starts the cycle after txDone
        e.data = 8'hFF; e.len = FRAME_LEN; exp_q.push_back(e);
        e.data = 8'h00; e.len = FRAME_LEN; exp_q.push_back(e);
        txData   = 8'hFF;
        txEnable = 1'b1;
        @(negedge clk);
        txData = 8'h00;
        n = 0;
        while (txDone !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", {31'd0, txDone}, 1);
        @(negedge clk);
        check("b2b_restart", {30'd0, busyTx, tx}, 32'd2);
        txEnable = 1'b0;
        wait_not_busy(300);
        repeat (3) @(negedge clk);

        // Reset mid-frame, with a request presented alongside reset
        send(8'h96, ABORT_LEN);
        repeat (ABORT_LEN - 1) @(negedge clk);
        reset    = 1'b1;
        txEnable = 1'b1;
        txData   = 8'h11;
        @(negedge clk);
        check("abort_outputs", {29'd0, tx, busyTx, txDone}, 32'd4);
        reset    = 1'b0;
        txEnable = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_restart", {31'd0, busyTx}, 0);

        send(8'h5A, FRAME_LEN);
        send(8'h07, FRAME_LEN);
        send(8'h80, FRAME_LEN);
        wait_not_busy(300);
        repeat (5) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
